// File: rtl/ahb_hart_arbiter_if.sv
// AHB-lite bus bundle shared by the two hart-facing ports and the slave-facing port.
// master drives a request and sees responses; slave receives a request and answers it.
interface ahb_hart_arbiter_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic              hexcl;
    logic [7:0]        hmaster;
    logic [W_DATA-1:0] hwdata;
    logic              hready;
    logic [W_DATA-1:0] hartid;
    logic              hready_resp;
    logic              hresp;
    logic              hexokay;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hmaster,
        output hwdata, hready, hartid,
        input  hready_resp, hresp, hexokay, hrdata
    );

    modport slave (
        input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hmaster,
        input  hwdata,
        output hready_resp, hresp, hexokay, hrdata
    );
endinterface

// File: rtl/ahb_hart_arbiter.sv
// Two-hart AHB-lite arbiter with one-entry replay buffer per hart and per-hart hexokay routing.
// Define HART_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module ahb_hart_arbiter #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic                clk,
    input  logic                rst,
    ahb_hart_arbiter_if.slave   s0,
    ahb_hart_arbiter_if.slave   s1,
    ahb_hart_arbiter_if.master  m
);

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_HELD   = 2'd1,
        P_DPHASE = 2'd2
    } port_st_e;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              mastlock;
        logic              excl;
        logic [7:0]        master;
    } req_t;

    req_t              live_req [2];
    req_t              buf_out  [2];
    logic [1:0]        live_vld;
    logic [1:0]        held_vec;
    logic [1:0]        hready_up;
    logic [1:0]        cand;
    logic [1:0]        elig;
    logic              accept;
    logic              lock_act;
    logic              tie;
    logic              tie_idx;
    logic              win_vld;
    logic              win_idx;
    req_t              win_req;

    logic              lock_q, lock_d;
    logic              lock_idx_q, lock_idx_d;
    logic              own_vld_q, own_vld_d;
    logic              own_idx_q, own_idx_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic              hartid_q, hartid_d;

    assign live_req[0] = '{addr: s0.haddr, write: s0.hwrite, size: s0.hsize, burst: s0.hburst,
                           prot: s0.hprot, mastlock: s0.hmastlock, excl: s0.hexcl,
                           master: s0.hmaster};
    assign live_req[1] = '{addr: s1.haddr, write: s1.hwrite, size: s1.hsize, burst: s1.hburst,
                           prot: s1.hprot, mastlock: s1.hmastlock, excl: s1.hexcl,
                           master: s1.hmaster};

    // BUSY (01) carries no request, and SEQ is re-issued downstream as NONSEQ.
    assign live_vld = {s1.htrans[1], s0.htrans[1]};

    logic unused_htrans_lsb;
    assign unused_htrans_lsb = s0.htrans[0] ^ s1.htrans[0];

    // Reset wins over any candidate so a held request cannot slip out during reset.
    assign accept = m.hready_resp & ~rst;

    // ------------------------------------------------------------------
    // Per-port state: IDLE / HELD / DPHASE plus the one-entry buffer
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        port_st_e st_q, st_d;
        req_t     buf_q, buf_d;
        logic     is_win;
        logic     rdy;

        assign is_win       = win_vld && (win_idx == 1'(gi));
        assign held_vec[gi] = (st_q == P_HELD);
        assign hready_up[gi] = rdy;
        assign buf_out[gi]  = buf_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q  <= P_IDLE;
                buf_q <= '0;
            end else begin
                st_q  <= st_d;
                buf_q <= buf_d;
            end
        end

        always_comb begin
            st_d  = st_q;
            buf_d = buf_q;
            if (accept) begin
                if (is_win) begin
                    st_d = P_DPHASE;
                end else if (st_q == P_HELD) begin
                    st_d = P_HELD;
                end else if (live_vld[gi]) begin
                    st_d  = P_HELD;
                    buf_d = live_req[gi];
                end else begin
                    st_d = P_IDLE;
                end
            end else if (st_q == P_IDLE && live_vld[gi] && !rst) begin
                // An idle hart still sees hready high during a downstream stall,
                // so its request is taken now and replayed later.
                st_d  = P_HELD;
                buf_d = live_req[gi];
            end
        end

        always_comb begin
            unique case (st_q)
                P_HELD:   rdy = 1'b0;
                P_DPHASE: rdy = m.hready_resp;
                default:  rdy = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef HART_ARB_FIXED_PRIO_EN
    assign tie_idx = 1'b0;
`else
    logic last_q, last_d;

    // last_q names the port that won the most recent tie; the other port wins the next one.
    assign tie_idx = ~last_q;
    assign last_d  = tie ? win_idx : last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cand[i] = held_vec[i] | (live_vld[i] & hready_up[i]);
        end
        // A locked owner that stops requesting releases the lock in the same cycle.
        lock_act = lock_q & cand[lock_idx_q];
        elig[0]  = cand[0] & ~(lock_act & lock_idx_q);
        elig[1]  = cand[1] & ~(lock_act & ~lock_idx_q);
        tie      = accept & (&elig);
        win_vld  = accept & (|elig);
        win_idx  = tie ? tie_idx : elig[1];
        win_req  = held_vec[win_idx] ? buf_out[win_idx] : live_req[win_idx];
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        own_vld_d  = own_vld_q;
        own_idx_d  = own_idx_q;
        addr_d     = addr_q;
        hartid_d   = hartid_q;
        if (accept) begin
            own_vld_d = win_vld;
            own_idx_d = win_idx;
            if (lock_q && !cand[lock_idx_q]) begin
                lock_d = 1'b0;
            end
            if (win_vld) begin
                addr_d   = win_req.addr;
                hartid_d = win_idx;
                if (win_req.mastlock) begin
                    lock_d     = 1'b1;
                    lock_idx_d = win_idx;
                end else if (lock_q && lock_idx_q == win_idx) begin
                    lock_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            own_vld_q  <= 1'b0;
            own_idx_q  <= 1'b0;
            addr_q     <= '0;
            hartid_q   <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            own_vld_q  <= own_vld_d;
            own_idx_q  <= own_idx_d;
            addr_q     <= addr_d;
            hartid_q   <= hartid_d;
        end
    end

    // ------------------------------------------------------------------
    // Downstream address phase and response routing
    // ------------------------------------------------------------------
    assign m.htrans    = win_vld ? 2'b10 : 2'b00;
    assign m.haddr     = win_vld ? win_req.addr : addr_q;
    assign m.hartid    = W_DATA'(win_vld ? win_idx : hartid_q);
    assign m.hwrite    = win_vld & win_req.write;
    assign m.hsize     = win_vld ? win_req.size  : 3'b000;
    assign m.hburst    = win_vld ? win_req.burst : 3'b000;
    assign m.hprot     = win_vld ? win_req.prot  : 4'b0000;
    assign m.hmastlock = win_vld & win_req.mastlock;
    assign m.hexcl     = win_vld & win_req.excl;
    assign m.hmaster   = win_vld ? win_req.master : 8'h00;
    assign m.hready    = m.hready_resp;

    // Write data follows the data-phase owner, not the address-phase winner.
    assign m.hwdata    = !own_vld_q ? '0 : (own_idx_q ? s1.hwdata : s0.hwdata);

    assign s0.hready_resp = hready_up[0];
    assign s1.hready_resp = hready_up[1];
    assign s0.hresp       = m.hresp;
    assign s1.hresp       = m.hresp;
    assign s0.hexokay     = m.hexokay & own_vld_q & ~own_idx_q;
    assign s1.hexokay     = m.hexokay & own_vld_q & own_idx_q;
    assign s0.hrdata      = m.hrdata;
    assign s1.hrdata      = m.hrdata;

endmodule

// File: tb/tb_ahb_hart_arbiter.sv
// Directed bench for ahb_hart_arbiter: each task drives one scenario and checks inline.
module tb_ahb_hart_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ahb_hart_arbiter_if #(.W_ADDR(32), .W_DATA(32)) s0_bus ();
    ahb_hart_arbiter_if #(.W_ADDR(32), .W_DATA(32)) s1_bus ();
    ahb_hart_arbiter_if #(.W_ADDR(32), .W_DATA(32)) m_bus ();

    ahb_hart_arbiter #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk (clk),
        .rst (rst),
        .s0  (s0_bus),
        .s1  (s1_bus),
        .m   (m_bus)
    );

    always #5 clk = ~clk;

`ifdef HART_ARB_FIXED_PRIO_EN
    localparam logic [31:0] RR3_ID = 32'd0, RR3_ADDR = 32'h30, RR4_ID = 32'd1, RR4_ADDR = 32'h40;
`else
    localparam logic [31:0] RR3_ID = 32'd1, RR3_ADDR = 32'h40, RR4_ID = 32'd0, RR4_ADDR = 32'h30;
`endif

    task automatic tick();
        if (m_bus.htrans == 2'b10 && m_bus.hready_resp)
            $display("txn t=%0t hart=%0d addr=%h write=%0b lock=%0b excl=%0b", $time,
                     m_bus.hartid, m_bus.haddr, m_bus.hwrite, m_bus.hmastlock, m_bus.hexcl);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic lk, input logic ex, input logic [31:0] wd);
        if (p == 0) begin
            s0_bus.htrans = trans; s0_bus.haddr = addr; s0_bus.hwrite = wr;
            s0_bus.hmastlock = lk; s0_bus.hexcl = ex; s0_bus.hwdata = wd;
        end else begin
            s1_bus.htrans = trans; s1_bus.haddr = addr; s1_bus.hwrite = wr;
            s1_bus.hmastlock = lk; s1_bus.hexcl = ex; s1_bus.hwdata = wd;
        end
    endtask

    task automatic idle_both();
        s0_bus.htrans = 2'b00; s0_bus.hmastlock = 1'b0; s0_bus.hexcl = 1'b0;
        s1_bus.htrans = 2'b00; s1_bus.hmastlock = 1'b0; s1_bus.hexcl = 1'b0;
    endtask

    task automatic slave(input logic rdy, input logic ex, input logic [31:0] rd);
        m_bus.hready_resp = rdy;
        m_bus.hexokay     = ex;
        m_bus.hrdata      = rd;
        m_bus.hresp       = 1'b0;
    endtask

    task automatic do_reset();
        idle_both();
        slave(1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_both();
        slave(1'b1, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (s0_bus.hready_resp !== 1'b1) begin errors++; $display("FAIL reset_s0_rdy: got %b want 1", s0_bus.hready_resp); end
        checks++; if (s1_bus.hready_resp !== 1'b1) begin errors++; $display("FAIL reset_s1_rdy: got %b want 1", s1_bus.hready_resp); end
        checks++; if (s0_bus.hexokay !== 1'b0) begin errors++; $display("FAIL reset_s0_exok: got %b want 0", s0_bus.hexokay); end
        checks++; if (s1_bus.hexokay !== 1'b0) begin errors++; $display("FAIL reset_s1_exok: got %b want 0", s1_bus.hexokay); end
        checks++; if (m_bus.htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b want 00", m_bus.htrans); end
        checks++; if (m_bus.hartid !== 32'd0) begin errors++; $display("FAIL reset_hartid: got %0d want 0", m_bus.hartid); end
    endtask

    task automatic test_single();
        drive(0, 2'b10, 32'h8000_0010, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (m_bus.haddr !== 32'h8000_0010) begin errors++; $display("FAIL single_addr: got %h want 80000010", m_bus.haddr); end
        checks++; if (m_bus.htrans !== 2'b10) begin errors++; $display("FAIL single_htrans: got %b want 10", m_bus.htrans); end
        checks++; if (m_bus.hartid !== 32'd0) begin errors++; $display("FAIL single_hartid: got %0d want 0", m_bus.hartid); end
        checks++; if (s1_bus.hready_resp !== 1'b1) begin errors++; $display("FAIL single_s1_rdy_a: got %b want 1", s1_bus.hready_resp); end
        tick();
        idle_both();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (s0_bus.hready_resp !== 1'b0) begin errors++; $display("FAIL single_s0_stall: got %b want 0", s0_bus.hready_resp); end
        checks++; if (s1_bus.hready_resp !== 1'b1) begin errors++; $display("FAIL single_s1_rdy_b: got %b want 1", s1_bus.hready_resp); end
        checks++; if (m_bus.haddr !== 32'h8000_0010) begin errors++; $display("FAIL single_addr_hold: got %h want 80000010", m_bus.haddr); end
        tick();
        slave(1'b1, 1'b0, 32'hCAFE_F00D);
        #1;
        checks++; if (s0_bus.hready_resp !== 1'b1) begin errors++; $display("FAIL single_s0_done: got %b want 1", s0_bus.hready_resp); end
        checks++; if (s0_bus.hrdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL single_rdata: got %h want cafef00d", s0_bus.hrdata); end
        tick();
    endtask

    task automatic test_contend();
        drive(0, 2'b10, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
        slave(1'b1, 1'b0, 32'h0);
        #1;
        checks++; if (m_bus.haddr !== 32'h100) begin errors++; $display("FAIL contend_addr0: got %h want 100", m_bus.haddr); end
        checks++; if (m_bus.hartid !== 32'd0) begin errors++; $display("FAIL contend_id0: got %0d want 0", m_bus.hartid); end
        tick();
        drive(0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'hAAAA_5555);
        drive(1, 2'b00, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
        #1;
        checks++; if (m_bus.hwdata !== 32'hAAAA_5555) begin errors++; $display("FAIL contend_wdata0: got %h want aaaa5555", m_bus.hwdata); end
        checks++; if (s1_bus.hready_resp !== 1'b0) begin errors++; $display("FAIL contend_s1_held: got %b want 0", s1_bus.hready_resp); end
        checks++; if (m_bus.haddr !== 32'h200) begin errors++; $display("FAIL contend_addr1: got %h want 200", m_bus.haddr); end
        checks++; if (m_bus.hartid !== 32'd1) begin errors++; $display("FAIL contend_id1: got %0d want 1", m_bus.hartid); end
        checks++; if (m_bus.hwrite !== 1'b1) begin errors++; $display("FAIL contend_write1: got %b want 1", m_bus.hwrite); end
        tick();
        #1;
        checks++; if (m_bus.hwdata !== 32'h1234_5678) begin errors++; $display("FAIL contend_wdata1: got %h want 12345678", m_bus.hwdata); end
        checks++; if (s1_bus.hready_resp !== 1'b1) begin errors++; $display("FAIL contend_s1_done: got %b want 1", s1_bus.hready_resp); end
        checks++; if (m_bus.htrans !== 2'b00) begin errors++; $display("FAIL contend_idle: got %b want 00", m_bus.htrans); end
        tick();
    endtask

    task automatic test_rr_order();
        do_reset();
        drive(0, 2'b10, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (m_bus.hartid !== 32'd0) begin errors++; $display("FAIL rr_g1: got %0d want 0", m_bus.hartid); end
        tick();
        idle_both();
        #1;
        checks++; if (m_bus.hartid !== 32'd1 || m_bus.haddr !== 32'h20) begin errors++; $display("FAIL rr_g2: got id %0d addr %h want id 1 addr 20", m_bus.hartid, m_bus.haddr); end
        tick();
        drive(0, 2'b10, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (m_bus.hartid !== RR3_ID || m_bus.haddr !== RR3_ADDR) begin errors++; $display("FAIL rr_g3: got id %0d addr %h want id %0d addr %h", m_bus.hartid, m_bus.haddr, RR3_ID, RR3_ADDR); end
        tick();
        idle_both();
        #1;
        checks++; if (m_bus.hartid !== RR4_ID || m_bus.haddr !== RR4_ADDR) begin errors++; $display("FAIL rr_g4: got id %0d addr %h want id %0d addr %h", m_bus.hartid, m_bus.haddr, RR4_ID, RR4_ADDR); end
        checks++; if (m_bus.htrans !== 2'b10) begin errors++; $display("FAIL rr_g4_trans: got %b want 10", m_bus.htrans); end
        tick();
        tick();
    endtask

    task automatic test_excl();
        idle_both();
        drive(0, 2'b10, 32'h300, 1'b0, 1'b0, 1'b1, 32'h0);
        #1;
        checks++; if (m_bus.hexcl !== 1'b1 || m_bus.haddr !== 32'h300) begin errors++; $display("FAIL excl_rd_addr: got excl %b addr %h want 1 300", m_bus.hexcl, m_bus.haddr); end
        tick();
        drive(0, 2'b10, 32'h300, 1'b1, 1'b0, 1'b1, 32'h0);
        slave(1'b1, 1'b1, 32'h5A5A_0001);
        #1;
        checks++; if (s0_bus.hexokay !== 1'b1) begin errors++; $display("FAIL excl_rd_exok: got %b want 1", s0_bus.hexokay); end
        checks++; if (s1_bus.hexokay !== 1'b0) begin errors++; $display("FAIL excl_rd_s1_exok: got %b want 0", s1_bus.hexokay); end
        checks++; if (m_bus.hwrite !== 1'b1 || m_bus.hexcl !== 1'b1) begin errors++; $display("FAIL excl_wr_ctrl: got write %b excl %b want 1 1", m_bus.hwrite, m_bus.hexcl); end
        tick();
        drive(0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFEED_0300);
        #1;
        checks++; if (s0_bus.hexokay !== 1'b1) begin errors++; $display("FAIL excl_wr_exok: got %b want 1", s0_bus.hexokay); end
        checks++; if (s1_bus.hexokay !== 1'b0) begin errors++; $display("FAIL excl_wr_s1_exok: got %b want 0", s1_bus.hexokay); end
        tick();
        #1;
        checks++; if (s0_bus.hexokay !== 1'b0) begin errors++; $display("FAIL excl_no_owner: got %b want 0", s0_bus.hexokay); end
        slave(1'b1, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        drive(0, 2'b10, 32'h400, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (m_bus.hartid !== 32'd0 || m_bus.hmastlock !== 1'b1) begin errors++; $display("FAIL lock_first: got id %0d lock %b want 0 1", m_bus.hartid, m_bus.hmastlock); end
        tick();
        drive(0, 2'b10, 32'h404, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (m_bus.hartid !== 32'd0 || m_bus.haddr !== 32'h404) begin errors++; $display("FAIL lock_unlocked_wr: got id %0d addr %h want 0 404", m_bus.hartid, m_bus.haddr); end
        checks++; if (s1_bus.hready_resp !== 1'b0) begin errors++; $display("FAIL lock_s1_held: got %b want 0", s1_bus.hready_resp); end
        tick();
        drive(0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (m_bus.hartid !== 32'd1 || m_bus.haddr !== 32'h500) begin errors++; $display("FAIL lock_release: got id %0d addr %h want 1 500", m_bus.hartid, m_bus.haddr); end
        checks++; if (s1_bus.hready_resp !== 1'b0) begin errors++; $display("FAIL lock_s1_wait: got %b want 0", s1_bus.hready_resp); end
        tick();
        idle_both();
        #1;
        checks++; if (s1_bus.hready_resp !== 1'b1 || m_bus.htrans !== 2'b00) begin errors++; $display("FAIL lock_done: got rdy %b trans %b want 1 00", s1_bus.hready_resp, m_bus.htrans); end
        tick();
    endtask

    task automatic test_reset_held();
        do_reset();
        drive(0, 2'b10, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h700, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle_both();
        rst = 1'b1;
        #1;
        checks++; if (s1_bus.hready_resp !== 1'b0) begin errors++; $display("FAIL rsth_held: got %b want 0", s1_bus.hready_resp); end
        checks++; if (m_bus.htrans !== 2'b00) begin errors++; $display("FAIL rsth_trans_in_rst: got %b want 00", m_bus.htrans); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (s1_bus.hready_resp !== 1'b1) begin errors++; $display("FAIL rsth_s1_rdy: got %b want 1", s1_bus.hready_resp); end
        checks++; if (s0_bus.hready_resp !== 1'b1) begin errors++; $display("FAIL rsth_s0_rdy: got %b want 1", s0_bus.hready_resp); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_bus.htrans !== 2'b00) begin errors++; $display("FAIL rsth_no_replay%0d: got %b want 00", i, m_bus.htrans); end
            tick();
        end
    endtask

    initial begin
        s0_bus.hsize = 3'b010; s0_bus.hburst = 3'b000; s0_bus.hprot = 4'b0011; s0_bus.hmaster = 8'd0;
        s1_bus.hsize = 3'b010; s1_bus.hburst = 3'b000; s1_bus.hprot = 4'b0011; s1_bus.hmaster = 8'd1;
        s0_bus.hready = 1'b1; s0_bus.hartid = 32'd0; s1_bus.hready = 1'b1; s1_bus.hartid = 32'd0;
        s0_bus.haddr = 32'h0; s0_bus.hwrite = 1'b0; s0_bus.hwdata = 32'h0;
        s1_bus.haddr = 32'h0; s1_bus.hwrite = 1'b0; s1_bus.hwdata = 32'h0;
        idle_both();
        slave(1'b1, 1'b0, 32'h0);
        test_reset();
        test_single();
        test_contend();
        test_rr_order();
        test_excl();
        test_lock();
        test_reset_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
